// File: rtl/my_alu_pkg.sv
// Shared width default and operation encodings for the my_alu datapath.
package my_alu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_SHL = 2'd3;

endpackage : my_alu_pkg

// File: rtl/my_alu_mult.sv
// Combinational signed WIDTHxWIDTH Baugh-Wooley shift-add multiplier, full 2*WIDTH product.
module my_alu_mult #(
  parameter int unsigned WIDTH = my_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] acc;
  logic [PW-1:0] row;
  logic          pp;

  // Sum shifted partial-product rows; sign-weighted terms are inverted and the
  // correction constants 2^WIDTH and 2^(2*WIDTH-1) are preloaded into the sum.
  always_comb begin
    acc = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    row = '0;
    pp  = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      row = '0;
      for (int j = 0; j < int'(WIDTH); j++) begin
        pp = a[j] & b[i];
        if ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)) begin
          pp = ~pp;
        end
        row[i+j] = pp;
      end
      acc = acc + row;
    end
    product_c = acc;
  end

endmodule : my_alu_mult

// File: rtl/my_alu.sv
// Signed ALU: ADD/SUB/MUL/SHL selected by sel, result registered with one-cycle latency.
module my_alu
  import my_alu_pkg::*;
#(
  parameter int unsigned WIDTH = my_alu_pkg::WIDTH
) (
  output logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             sub_c;
  logic [WIDTH-1:0] b_op_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] shl_c;
  logic [WIDTH-1:0] prod_lo_c;
  logic [WIDTH-1:0] prod_hi_unused;
  logic [WIDTH-1:0] result_c;

  // Only the low half of the product is kept; high half is truncated away.
  my_alu_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .a         (A),
    .b         (B),
    .product_c ({prod_hi_unused, prod_lo_c})
  );

  // Shared adder: subtraction is A + ~B + 1.
  always_comb begin
    sub_c  = (sel == OP_SUB);
    b_op_c = sub_c ? ~B : B;
    sum_c  = A + b_op_c + WIDTH'(sub_c);
  end

  // Log-stage barrel shifter; any count of WIDTH or more clears the result.
  always_comb begin
    shl_c = A;
    for (int k = 0; k < int'(SHW); k++) begin
      if (B[k]) begin
        shl_c = shl_c << (1 << k);
      end
    end
    if (|B[WIDTH-1:SHW]) begin
      shl_c = '0;
    end
  end

  // Result select.
  always_comb begin
    result_c = sum_c;
    unique case (sel)
      OP_ADD:  result_c = sum_c;
      OP_SUB:  result_c = sum_c;
      OP_MUL:  result_c = prod_lo_c;
      OP_SHL:  result_c = shl_c;
      default: result_c = sum_c;
    endcase
  end

  // Result register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S <= '0;
    end else begin
      S <= result_c;
    end
  end

endmodule : my_alu

// File: tb/tb_my_alu.sv
// Directed table plus random sweep for my_alu, checked against a behavioural model.
module tb_my_alu;
  import my_alu_pkg::*;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic [7:0] S;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] sel;
  logic       clk;
  logic       rst_n;

  int errors = 0;
  int checks = 0;

  vec_t vecs [14];

  my_alu dut (
    .S     (S),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: S=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] pr;
    logic [7:0]         r;
    r = 8'h00;
    case (op)
      OP_ADD: r = 8'(a + b);
      OP_SUB: r = 8'(a - b);
      OP_MUL: begin
        pr = $signed(a) * $signed(b);
        r  = pr[7:0];
      end
      default: r = (b >= 8'd8) ? 8'h00 : 8'(a << b);
    endcase
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{OP_ADD, 8'h01, 8'h80, 8'h81, "add_1_m128"};
    vecs[1]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, "add_wrap"};
    vecs[2]  = '{OP_SUB, 8'h01, 8'h01, 8'h00, "sub_zero"};
    vecs[3]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, "sub_wrap"};
    vecs[4]  = '{OP_MUL, 8'h01, 8'hFF, 8'hFF, "mul_1_m1"};
    vecs[5]  = '{OP_MUL, 8'h01, 8'h01, 8'h01, "mul_1_1"};
    vecs[6]  = '{OP_MUL, 8'h10, 8'h10, 8'h00, "mul_trunc"};
    vecs[7]  = '{OP_MUL, 8'h80, 8'hFF, 8'h80, "mul_m128_m1"};
    vecs[8]  = '{OP_MUL, 8'hFD, 8'h05, 8'hF1, "mul_m3_5"};
    vecs[9]  = '{OP_SHL, 8'h01, 8'h01, 8'h02, "shl_1"};
    vecs[10] = '{OP_SHL, 8'h01, 8'h08, 8'h00, "shl_8"};
    vecs[11] = '{OP_SHL, 8'h81, 8'h07, 8'h80, "shl_7"};
    vecs[12] = '{OP_SHL, 8'h81, 8'hFF, 8'h00, "shl_255"};
    vecs[13] = '{OP_SHL, 8'h81, 8'h00, 8'h81, "shl_0"};

    // Reset held with live inputs: S must stay cleared across edges.
    rst_n = 1'b0;
    A     = 8'd5;
    B     = 8'd3;
    sel   = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", S, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", S, 8'h00);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", S, 8'h08);

    // Directed table, one vector per clock.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sel = vecs[i].sel;
      A   = vecs[i].a;
      B   = vecs[i].b;
      @(posedge clk);
      #1;
      check(vecs[i].name, S, vecs[i].exp);
    end

    // Result holds between edges while inputs change.
    @(negedge clk);
    sel = OP_ADD;
    A   = 8'h11;
    B   = 8'h22;
    #1;
    check("hold_between_edges", S, 8'h81);

    // Asynchronous clear mid-cycle with a nonzero result pending.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", S, 8'h00);
    @(posedge clk);
    #1;
    check("async_clear_discard", S, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Random sweep against the model.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] exp;
      @(negedge clk);
      sel = 2'($urandom_range(0, 3));
      A   = 8'($urandom);
      B   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      exp = model(sel, A, B);
      @(posedge clk);
      #1;
      check("random", S, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_my_alu
